// File: rtl/fmul_pkg.sv
// Shared constants and types for the fmul issue/retire stage.
// Flag bit positions follow the fcsr.fflags layout.
package fmul_pkg;
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_LAT   = 1;

    localparam logic [31:0] QNAN = 32'hFFC00000;

    typedef struct packed {
        logic [31:0] rslt;
        logic [4:0]  flag;
    } rent_t;

    // Clear takes effect before the new flags are ORed in.
    function automatic logic [4:0] flag_merge(input logic [4:0] acc,
                                              input logic       clr,
                                              input logic [4:0] add);
        return (clr ? 5'b00000 : acc) | add;
    endfunction
endpackage

// File: rtl/fmul_issue_chk.sv
// Invariants of the issue stage: credit bound and no push into a full FIFO.
module fmul_issue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic          pop,
    input logic          full,
    input logic [CW-1:0] cnt
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && full && !pop));

    a_cnt_range: assert property (@(posedge clk) disable iff (!reset)
        cnt <= CW'(DEPTH));
endmodule

// File: rtl/fmul_rfifo.sv
// Result FIFO: DEPTH entries of {result, flags}, extra pointer MSB for full/empty.
// Head output is forced to zero while empty so stale entries never show.
module fmul_rfifo
    import fmul_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  rent_t din,
    input  logic  pop,
    output rent_t dout,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    rent_t       mem_r [DEPTH];
    logic        push_s;
    logic        pop_s;

    // Status, qualified handshakes and head read.
    always_comb begin
        empty  = (wr_ptr_r == rd_ptr_r);
        full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s  = pop & ~empty;
        push_s = push & (~full | pop_s);
        if (empty) begin
            dout = '0;
        end else begin
            dout = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // Pointer advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/fmul_issue.sv
// Issue/retire wrapper for an external fmul: operand registers, in-flight
// tracking, credit-based result FIFO and sticky exception flags.
module fmul_issue
    import fmul_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ack,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] fx,
    output logic [31:0] fy,
    input  logic [31:0] frslt,
    input  logic [4:0]  fflag,
    output logic [31:0] rslt,
    output logic [4:0]  flag,
    output logic        valid,
    input  logic        rdy,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [CW-1:0]  cnt_r;
    logic [LAT-1:0] infl_r;
    logic [31:0]    fx_r;
    logic [31:0]    fy_r;
    logic [4:0]     fflags_r;
    logic           issue_s;
    logic           retire_s;
    logic           pop_s;
    logic           full_s;
    logic           empty_s;
    rent_t          cap_s;
    rent_t          head_s;

    // Handshakes and output mapping; ack looks only at credit, never at rdy.
    always_comb begin
        ack         = reset & (cnt_r < CNT_MAX);
        issue_s     = req & ack;
        retire_s    = infl_r[LAT-1];
        pop_s       = ~empty_s & rdy;
        cap_s.rslt  = frslt;
        cap_s.flag  = fflag;
        fx          = fx_r;
        fy          = fy_r;
        rslt        = head_s.rslt;
        flag        = head_s.flag;
        valid       = ~empty_s;
        fflags      = fflags_r;
        busy        = (cnt_r != '0);
    end

    // Operand registers and in-flight valid shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fx_r   <= 32'h0000_0000;
            fy_r   <= 32'h0000_0000;
            infl_r <= '0;
        end else begin
            if (issue_s) begin
                fx_r <= x;
                fy_r <= y;
            end
            infl_r <= LAT'({infl_r, issue_s});
        end
    end

    // Credit counter: in-flight plus buffered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else begin
            case ({issue_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Sticky accumulated exception flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags_r <= 5'b00000;
        end else if (retire_s) begin
            fflags_r <= flag_merge(fflags_r, fflags_clr, fflag);
        end else if (fflags_clr) begin
            fflags_r <= 5'b00000;
        end else begin
            fflags_r <= fflags_r;
        end
    end

    fmul_rfifo #(.DEPTH(DEPTH)) u_rfifo (
        .clk   (clk),
        .reset (reset),
        .push  (retire_s),
        .din   (cap_s),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    fmul_issue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (retire_s),
        .pop   (pop_s),
        .full  (full_s),
        .cnt   (cnt_r)
    );
endmodule

// File: tb/tb_fmul_issue.sv
// Bench for fmul_issue: a stand-in multiplier, a queue-based reference model,
// a table of known products and directed/random handshake sequences.
module tb_fmul_issue;
    import fmul_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic        clk;
    logic        reset;
    logic        req;
    logic        ack;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] fx;
    logic [31:0] fy;
    logic [31:0] frslt;
    logic [4:0]  fflag;
    logic [31:0] rslt;
    logic [4:0]  flag;
    logic        valid;
    logic        rdy;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    fmul_issue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .x(x), .y(y),
        .fx(fx), .fy(fy), .frslt(frslt), .fflag(fflag), .rslt(rslt),
        .flag(flag), .valid(valid), .rdy(rdy), .fflags(fflags),
        .fflags_clr(fflags_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known IEEE products, otherwise an arbitrary but deterministic mix.
    function automatic logic [36:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        case ({a, b})
            64'h3FC00000_40000000: return {32'h40400000, 5'b00000};
            64'h7F800000_00000000: return {QNAN, 5'b10000};
            64'h7F000000_7F000000: return {32'h7F800000, 5'b00101};
            64'h3F800001_3F800001: return {32'h3F800002, 5'b00001};
            default: begin
                p = (a * b) ^ {b[15:0], a[31:16]};
                return {p, a[4:0] & b[9:5]};
            end
        endcase
    endfunction

    always_comb {frslt, fflag} = fmul_ref(fx, fy);

    // Reference model: every accepted op waits in pend until popped.
    typedef struct {
        logic [36:0] d;
        int          e;
    } ent_t;
    ent_t        pend[$];
    int          edge_n = 0;
    logic [4:0]  ff_m   = 5'b00000;
    logic [31:0] fx_m   = 32'h0;
    logic [31:0] fy_m   = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        ff_m = 5'b00000;
        fx_m = 32'h0;
        fy_m = 32'h0;
    endtask

    // One clock: compare outputs, then advance model by the handshakes seen.
    task automatic step();
        logic        exp_ack;
        logic        exp_val;
        logic        iss;
        logic        pp;
        logic        clr;
        logic        any;
        logic [4:0]  orx;
        logic [31:0] xs;
        logic [31:0] ys;
        logic [36:0] hd;
        ent_t        ne;
        #1;
        exp_ack = (pend.size() < DEPTH);
        exp_val = (pend.size() > 0) && (pend[0].e + LAT <= edge_n);
        hd      = exp_val ? pend[0].d : 37'd0;
        chk("ack",    32'(ack),    32'(exp_ack));
        chk("valid",  32'(valid),  32'(exp_val));
        chk("busy",   32'(busy),   32'(pend.size() != 0));
        chk("rslt",   rslt,        hd[36:5]);
        chk("flag",   32'(flag),   32'(hd[4:0]));
        chk("fflags", 32'(fflags), 32'(ff_m));
        chk("fx",     fx,          fx_m);
        chk("fy",     fy,          fy_m);
        iss = req && exp_ack;
        pp  = exp_val && rdy;
        clr = fflags_clr;
        xs  = x;
        ys  = y;
        @(posedge clk);
        edge_n++;
        any = 1'b0;
        orx = 5'b00000;
        foreach (pend[i]) begin
            if (pend[i].e + LAT == edge_n) begin
                any = 1'b1;
                orx = orx | pend[i].d[4:0];
            end
        end
        if (any)      ff_m = (clr ? 5'b00000 : ff_m) | orx;
        else if (clr) ff_m = 5'b00000;
        if (pp) void'(pend.pop_front());
        if (iss) begin
            ne.d = fmul_ref(xs, ys);
            ne.e = edge_n;
            pend.push_back(ne);
            fx_m = xs;
            fy_m = ys;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        req = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [4:0]  f;
        logic [4:0]  ff;
    } vec_t;
    vec_t vt[4];

    int acc;

    initial begin
        vt[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 5'b00000};
        vt[1] = '{32'h7F800000, 32'h00000000, 32'hFFC00000, 5'b10000, 5'b10000};
        vt[2] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00101, 5'b10101};
        vt[3] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 5'b10101};

        reset = 1'b0; req = 1'b0; rdy = 1'b0; fflags_clr = 1'b0;
        x = 32'h0; y = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ack",    32'(ack),    32'h0);
        chk("rst_valid",  32'(valid),  32'h0);
        chk("rst_busy",   32'(busy),   32'h0);
        chk("rst_fflags", 32'(fflags), 32'h0);
        chk("rst_fx",     fx,          32'h0);
        chk("rst_rslt",   rslt,        32'h0);
        reset = 1'b1;

        // Known products, one at a time, with cumulative sticky flags.
        for (int i = 0; i < 4; i++) begin
            x = vt[i].x; y = vt[i].y; req = 1'b1; rdy = 1'b0;
            step();
            req = 1'b0;
            step();
            chk("tbl_valid",  32'(valid),  32'h1);
            chk("tbl_rslt",   rslt,        vt[i].r);
            chk("tbl_flag",   32'(flag),   32'(vt[i].f));
            chk("tbl_fflags", 32'(fflags), 32'(vt[i].ff));
            rdy = 1'b1;
            step();
            rdy = 1'b0;
        end

        // Back-to-back inf*0 then overflow, from clean flags.
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
        rdy = 1'b1; req = 1'b1;
        x = 32'h7F800000; y = 32'h00000000; step();
        x = 32'h7F000000; y = 32'h7F000000; step();
        drain(3);
        chk("b2b_fflags", 32'(fflags), 32'h15);

        // Clear on the same edge as an NX capture.
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
        req = 1'b1; x = 32'h7F800000; y = 32'h00000000; step();
        req = 1'b0; step(); step();
        chk("pre_clr_fflags", 32'(fflags), 32'h10);
        req = 1'b1; x = 32'h3F800001; y = 32'h3F800001; step();
        req = 1'b0; fflags_clr = 1'b1; step();
        fflags_clr = 1'b0;
        chk("clr_nx_fflags", 32'(fflags), 32'h01);
        drain(3);

        // Back-pressure: six requests, only DEPTH accepted.
        rdy = 1'b0; req = 1'b1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom;
            #1;
            if (ack) acc++;
            step();
        end
        chk("bp_accepted", 32'(acc), 32'(DEPTH));
        chk("bp_ack_low",  32'(ack), 32'h0);
        req = 1'b0; rdy = 1'b1;
        step();
        chk("bp_ack_back", 32'(ack), 32'h1);
        drain(5);

        // Full FIFO with simultaneous traffic both ways.
        rdy = 1'b0; req = 1'b1;
        for (int i = 0; i < 8 && pend.size() < DEPTH; i++) begin
            x = $urandom; y = $urandom; step();
        end
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x = $urandom; y = $urandom; step();
        end
        drain(6);

        // Reset mid-stream with flagged work outstanding.
        rdy = 1'b0; req = 1'b1;
        x = 32'h7F800000; y = 32'h00000000; step();
        x = $urandom; y = $urandom; step();
        req = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(valid),       32'h0);
        chk("mid_rst_busy",   32'(busy),        32'h0);
        chk("mid_rst_fflags", 32'(fflags),      32'h0);
        chk("mid_rst_cnt",    32'(dut.cnt_r),   32'h0);
        chk("mid_rst_ack",    32'(ack),         32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 1'b1; rdy = 1'b1; x = 32'h3FC00000; y = 32'h40000000; step();
        req = 1'b0; rdy = 1'b0; step();
        chk("post_rst_rslt", rslt, 32'h40400000);
        drain(2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req        = ($urandom_range(0, 3) != 0);
            rdy        = ($urandom_range(0, 3) != 0);
            fflags_clr = ($urandom_range(0, 15) == 0);
            x = $urandom; y = $urandom;
            step();
        end
        fflags_clr = 1'b0;
        drain(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fmul_issue.md
# fmul_issue

Sequential issue/retire stage wrapped around the combinational `fmul` single-precision multiplier. It accepts operand pairs over a req/ack handshake and registers them onto the multiplier inputs. It tracks in-flight operations and captures the multiplier's result and exception flags into a result FIFO with valid/ready output. It also keeps sticky accumulated exception flags, in the style of an fcsr.fflags register. `fmul` is instantiated beside this block by the parent, so this block can be reused unchanged with a pipelined multiplier.

## Interface
Parameters:
- `DEPTH`, 4: result FIFO entries; power of 2, ≥2.
- `LAT`, 1: edges from operand register load to result capture; 1 for the combinational `fmul`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  operand pair valid.
- `ack`  out  1  operand pair accepted this cycle when `req & ack`.
- `x`, `y`  in  32  IEEE-754 single operands.
- `fx`, `fy`  out  32  registered operands to `fmul`.
- `frslt`  in  32  `fmul` result.
- `fflag`  in  5  `fmul` flags; [4] NV, [3] DZ, [2] OF, [1] UF, [0] NX.
- `rslt`  out  32  FIFO head result.
- `flag`  out  5  FIFO head flags.
- `valid`  out  1  FIFO head valid.
- `rdy`  in  1  consumer ready; pop on `valid & rdy`.
- `fflags`  out  5  sticky OR of all retired flags.
- `fflags_clr`  in  1  clear `fflags`.
- `busy`  out  1  any op in flight or in FIFO.

## Operation
- Credit counter `cnt` = in-flight ops + FIFO occupancy, range 0..DEPTH.
- `ack` = reset deasserted & (`cnt` < DEPTH). It is registered-state only and never depends on `rdy`.
- Issue: on `req & ack`, load `fx<=x`, `fy<=y` and push a 1 into the LAT-bit in-flight valid shift register. Otherwise `fx`/`fy` hold and a 0 is shifted in.
- Retire: when the shift-register output bit is 1, push `{frslt, fflag}` into the FIFO.
- Retire also sets `fflags <= fflags | fflag`.
- `cnt` update: +1 on issue, −1 on pop, unchanged when both occur.
- Overflow is impossible by credit; a push into a full FIFO is an assertion failure.
- `fflags_clr` and a retire on the same edge: `fflags <= fflag` (clear first, then set). Without a retire, `fflags <= 0`.
- Push and pop on the same edge: both occur, including when the FIFO is full or holds one entry.
- A pop on an empty FIFO is ignored.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full/empty is decided by MSB compare.
- `busy` = (`cnt` != 0).
- Reset asserted (async) clears everything at once:
  - FIFO pointers, in-flight bits, `cnt`, `fflags`, `fx`, `fy` all go to 0.
  - In-flight and buffered results are discarded; no partial retire.
- Reset values of outputs: `ack`=0 while reset is low, 1 in the first cycle after release. `fx`=`fy`=0, `valid`=0, `rslt`=0, `flag`=0, `fflags`=0, `busy`=0.

## Timing
- Issue at edge E puts operands on `fx`/`fy` in cycle E+1. Capture happens at edge E+LAT.
- `valid` is high from the cycle after E+LAT, so minimum issue-to-valid is LAT edges.
- `rslt` and `flag` are driven from FIFO storage and are registered with no combinational path from `frslt`.
- Throughput: one op per cycle sustained when `rdy`=1 and DEPTH > LAT.
- Stall: with `rdy`=0, `ack` falls in the cycle after the DEPTH-th acceptance. It rises the cycle after the first pop.
- `fflags` reflects a retire or clear one cycle after its edge.

## Structure
- Package `fmul_pkg`:
  - flag index constants `FLG_NV=4`, `FLG_DZ=3`, `FLG_OF=2`, `FLG_UF=1`, `FLG_NX=0`;
  - default `DEPTH`/`LAT`;
  - canonical qNaN constant 32'hFFC00000 for benches.
- Sub-module `fmul_rfifo`: 37-bit × DEPTH synchronous FIFO with push/pop/full/empty and async active-low reset.
- The top holds the credit counter, in-flight shift register, operand registers and sticky flags.

## Test plan
- 1.5×2.0: `x`=3FC00000, `y`=40000000, LAT=1, `rdy`=1 → `valid` 1 edge later with `rslt`=40400000, `flag`=00000; `fflags`=00000.
- inf×0 (7F800000 × 00000000), then 7F000000 × 7F000000 back to back → results FFC00000/10000, then 7F800000/00101 in order; `fflags`=10101.
- Back-pressure, DEPTH=4, `rdy`=0, `req` held for 6 cycles → exactly 4 accepted; `ack`=0 after the 4th. `rdy`=1 drains 4 results in issue order with `ack` returning 1 cycle after the first pop.
- Capture of NX op (3F800001 × 3F800001, `flag`=00001) on the same edge as `fflags_clr` with prior `fflags`=10000 → `fflags`=00001.
- Reset pulled low mid-stream with 2 in flight/buffered → `valid`, `busy`, `fflags`, `cnt` go to 0 immediately. After release the first result is from a post-reset issue.
- Simultaneous push and pop with FIFO full (DEPTH=4) for 20 cycles at `rdy`=1 → no loss, no duplication, order preserved, `ack` stays consistent with `cnt`.
